iod_dly_ctrl: RTL and testbench
===============================

IOD_DLY_CTRL -- requirements
Module: iod_dly_ctrl

Interface
REQ-001 SHALL have parameter MAX_TAP, default 127, meaning highest legal delay-line tap index.
REQ-002 SHALL have parameter LOAD_TAP, default 1, meaning tap index restored by a LOAD; matches the IOD TX_DELAY_VAL setting.
REQ-003 SHALL have parameter MOVE_GAP, default 3, meaning idle cycles after each MOVE pulse, range 1-15.
REQ-004 SHALL have parameter LOAD_WAIT, default 4, meaning idle cycles after a LOAD pulse, range 1-15.
REQ-005 SHALL have ports:
  FAB_CLK  in  1  sole clock, rising edge.
  ARST_N  in  1  asynchronous active-low reset.
  REQ_VALID  in  1  request present.
  REQ_READY  out  1  controller can accept a request.
  REQ_OP  in  2  00 increment, 01 decrement, 10 load, 11 reserved.
  REQ_TAPS  in  8  tap steps for increment or decrement; ignored for load.
  DONE  out  1  one-cycle completion pulse.
  ERR  out  1  error qualifier, valid only while DONE=1.
  TAP_POS  out  8  current tap index.
  DELAY_LINE_MOVE  out  1  to IOD, one-cycle step pulse.
  DELAY_LINE_DIRECTION  out  1  to IOD, 1 increases delay.
  DELAY_LINE_LOAD  out  1  to IOD, one-cycle reload pulse.
  DELAY_LINE_OUT_OF_RANGE  in  1  from IOD, synchronous to FAB_CLK.

Function
REQ-006 SHALL implement the states IDLE, SETUP, PULSE, GAP, LOAD, LWAIT and FIN.
REQ-007 REQ_READY SHALL be 1 only in IDLE; a request is accepted on a cycle with REQ_VALID=1 and REQ_READY=1.
REQ-008 On acceptance, SHALL latch REQ_OP and REQ_TAPS; later input changes have no effect until FIN.
REQ-009 For an accepted increment or decrement with REQ_TAPS>0, SHALL go IDLE->SETUP and drive DIRECTION (1 for increment, 0 for decrement) from SETUP until FIN.
REQ-010 DIRECTION SHALL be stable at least one cycle before the first MOVE pulse.
REQ-011 SETUP SHALL last 1 cycle, then go to PULSE.
REQ-012 PULSE SHALL last 1 cycle, with MOVE=1 and the remaining count decremented.
REQ-013 On each PULSE cycle, TAP_POS SHALL update by +1 or -1 at the next edge.
REQ-014 GAP SHALL last MOVE_GAP cycles.
REQ-015 At the end of GAP, SHALL go to PULSE if the remaining count >0, otherwise to FIN.
REQ-016 For a request with N steps and no error, the first MOVE SHALL occur 2 cycles after acceptance, MOVE pulses SHALL be spaced MOVE_GAP+1 cycles apart, and DONE SHALL occur 2+N*(MOVE_GAP+1) cycles after acceptance.
REQ-017 A request with REQ_TAPS=0 SHALL go IDLE->FIN, with DONE=1 and ERR=0 one cycle after acceptance, and no MOVE pulse.
REQ-018 Range guard: a PULSE that would take TAP_POS above MAX_TAP or below 0 SHALL NOT be issued; the block SHALL instead go to FIN with ERR=1 and TAP_POS unchanged.
REQ-019 DELAY_LINE_OUT_OF_RANGE=1 sampled in any GAP cycle SHALL abort the request: go to FIN with ERR=1, issue no further MOVE, and keep TAP_POS as already counted.
REQ-020 For a load, SHALL go IDLE->LOAD; LOAD SHALL last 1 cycle with DELAY_LINE_LOAD=1, and TAP_POS SHALL become LOAD_TAP at the next edge.
REQ-021 After LOAD, LWAIT SHALL last LOAD_WAIT cycles, then go to FIN; DONE SHALL occur 2+LOAD_WAIT cycles after acceptance with ERR=0.
REQ-022 REQ_OP=11 SHALL go IDLE->FIN with ERR=1 and no IOD pulse.
REQ-023 FIN SHALL last 1 cycle with DONE=1, then go to IDLE; REQ_READY SHALL be 1 in the following cycle.
REQ-024 MOVE and LOAD SHALL never be 1 in the same cycle.
REQ-025 MOVE, LOAD, DONE and ERR SHALL be registered outputs.

Reset
REQ-026 ARST_N=0 SHALL immediately force state IDLE, REQ_READY=0, DONE=0, ERR=0, MOVE=0, LOAD=0, DIRECTION=0, TAP_POS=LOAD_TAP, and remaining count=0.
REQ-027 REQ_READY SHALL rise on the first FAB_CLK edge after ARST_N deasserts.
REQ-028 A reset mid-operation SHALL abandon the request with no DONE; the issuer is responsible for re-issuing a LOAD to resynchronise the IOD.

Verification
REQ-029 Reset, then increment with TAPS=3 and MOVE_GAP=3 -> MOVE pulses at acceptance+2, +6 and +10; DONE at +14; ERR=0; TAP_POS=4.
REQ-030 From TAP_POS=4, decrement with TAPS=6 -> 4 MOVE pulses; DONE with ERR=1; TAP_POS=0.
REQ-031 Increment with TAPS=10 and OUT_OF_RANGE forced to 1 in the GAP after the 2nd pulse -> no 3rd MOVE; DONE with ERR=1; TAP_POS=start+2.
REQ-032 Load with LOAD_WAIT=4 -> LOAD pulse at acceptance+1; DONE at +6; TAP_POS=1. Separately, REQ_OP=11 -> DONE at +1 with ERR=1.
REQ-033 Increment with TAPS=0 -> DONE at +1 with ERR=0, no MOVE pulse, REQ_READY=1 at +2.
REQ-034 ARST_N pulsed low during the GAP of an increment with TAPS=5 -> all outputs at reset values immediately, no DONE, REQ_READY=1 after release, TAP_POS=1.

Source files
------------

// File: rtl/iod_dly_ctrl.sv
// iod_dly_ctrl: sequences MOVE/LOAD pulses into an IOD delay line on request,
// tracks the tap index locally and reports completion with a DONE/ERR pair.
module iod_dly_ctrl #(
  parameter int MAX_TAP   = 127,
  parameter int LOAD_TAP  = 1,
  parameter int MOVE_GAP  = 3,
  parameter int LOAD_WAIT = 4
) (
  input  logic       FAB_CLK,
  input  logic       ARST_N,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [1:0] REQ_OP,
  input  logic [7:0] REQ_TAPS,
  output logic       DONE,
  output logic       ERR,
  output logic [7:0] TAP_POS,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  output logic       DELAY_LINE_LOAD,
  input  logic       DELAY_LINE_OUT_OF_RANGE
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_GAP, S_LOAD, S_LWAIT, S_FIN
  } state_t;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  localparam logic [7:0] LOAD_TAP_C = 8'(LOAD_TAP);
  localparam logic [7:0] MAX_TAP_C  = 8'(MAX_TAP);
  // Wait counters count down to zero, so they start one below the length.
  localparam logic [3:0] GAP_INIT   = 4'(MOVE_GAP - 1);
  localparam logic [3:0] LWAIT_INIT = 4'(LOAD_WAIT - 1);

  state_t     state_q;
  logic       ready_q, done_q, err_q, move_q, load_q, dir_q;
  logic [7:0] tap_q, cnt_q;
  logic [3:0] wcnt_q;

  logic       step_ok_d;
  logic [7:0] tap_d;

  // Range guard for the next step and the tap value a step produces.
  always_comb begin
    step_ok_d = dir_q ? (tap_q < MAX_TAP_C) : (tap_q != 8'd0);
    tap_d     = dir_q ? (tap_q + 8'd1) : (tap_q - 8'd1);
  end

  // Control FSM; every output is a register updated alongside the state.
  // The request opcode is captured by the state taken on acceptance plus
  // dir_q, and REQ_TAPS by cnt_q, so no separate opcode register is kept.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      move_q  <= 1'b0;
      load_q  <= 1'b0;
      dir_q   <= 1'b0;
      tap_q   <= LOAD_TAP_C;
      cnt_q   <= 8'd0;
      wcnt_q  <= 4'd0;
    end else begin
      move_q <= 1'b0;
      load_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (REQ_VALID && ready_q) begin
            ready_q <= 1'b0;
            cnt_q   <= REQ_TAPS;
            if (REQ_OP == OP_INC || REQ_OP == OP_DEC) begin
              if (REQ_TAPS == 8'd0) begin
                state_q <= S_FIN;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_SETUP;
                dir_q   <= (REQ_OP == OP_INC);
              end
            end else if (REQ_OP == OP_LOAD) begin
              state_q <= S_LOAD;
              load_q  <= 1'b1;
            end else begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        // Direction has been stable for this cycle; first step if legal.
        S_SETUP: begin
          if (step_ok_d) begin
            state_q <= S_PULSE;
            move_q  <= 1'b1;
          end else begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        S_PULSE: begin
          tap_q   <= tap_d;
          cnt_q   <= cnt_q - 8'd1;
          wcnt_q  <= GAP_INIT;
          state_q <= S_GAP;
        end
        // IOD range flag aborts at once; otherwise wait out the gap.
        S_GAP: begin
          if (DELAY_LINE_OUT_OF_RANGE) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else if (wcnt_q != 4'd0) begin
            wcnt_q <= wcnt_q - 4'd1;
          end else if (cnt_q == 8'd0) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end else if (step_ok_d) begin
            state_q <= S_PULSE;
            move_q  <= 1'b1;
          end else begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        S_LOAD: begin
          tap_q   <= LOAD_TAP_C;
          wcnt_q  <= LWAIT_INIT;
          state_q <= S_LWAIT;
        end
        S_LWAIT: begin
          if (wcnt_q != 4'd0) begin
            wcnt_q <= wcnt_q - 4'd1;
          end else begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          dir_q   <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign REQ_READY            = ready_q;
  assign DONE                 = done_q;
  assign ERR                  = err_q;
  assign TAP_POS              = tap_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign DELAY_LINE_DIRECTION = dir_q;
  assign DELAY_LINE_LOAD      = load_q;

endmodule

// File: tb/tb_iod_dly_ctrl.sv
// tb_iod_dly_ctrl: table of requests with hand-derived outcomes, scoreboarded
// against DONE, plus a mid-operation reset sequence.
module tb_iod_dly_ctrl;

  localparam int GAP = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_taps = 8'd0;
  logic       done, err, move, dir, load;
  logic [7:0] tap_pos;
  logic       oor = 1'b0;

  iod_dly_ctrl #(.MAX_TAP(127), .LOAD_TAP(1), .MOVE_GAP(GAP), .LOAD_WAIT(4)) dut (
    .FAB_CLK(clk), .ARST_N(rst_n),
    .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_OP(req_op), .REQ_TAPS(req_taps),
    .DONE(done), .ERR(err), .TAP_POS(tap_pos),
    .DELAY_LINE_MOVE(move), .DELAY_LINE_DIRECTION(dir),
    .DELAY_LINE_LOAD(load), .DELAY_LINE_OUT_OF_RANGE(oor)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [7:0] taps;
    int         oor_k;     // assert OUT_OF_RANGE in the GAP after this pulse (0 = never)
    int         exp_moves;
    int         exp_loads;
    int         exp_lat;   // DONE cycle counted from acceptance
    int         exp_err;
    int         exp_tap;
  } vec_t;

  vec_t vt[12];
  vec_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Issue one request, watch it to completion and score the outcome.
  task automatic run(input vec_t v);
    int   c, moves, loads, oor_on, waited;
    bit   fin;
    vec_t e;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk({v.name, " ready_before"}, int'(req_ready), 1);
    req_valid = 1'b1;
    req_op    = v.op;
    req_taps  = v.taps;
    sb.push_back(v);
    c = 0; moves = 0; loads = 0; oor_on = 0; fin = 1'b0;
    while (!fin && c < 2000) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        req_valid = 1'b0;
        req_op    = 2'b11;   // later input changes must be ignored
        req_taps  = 8'hFF;
      end
      if (oor_on != 0 && c == oor_on + 2) oor = 1'b0;
      if (move && load) chk({v.name, " move_and_load"}, 1, 0);
      if (move) begin
        chk({v.name, " move_cycle"}, c, 2 + moves * (GAP + 1));
        chk({v.name, " direction"}, int'(dir), (v.op == 2'b00) ? 1 : 0);
        moves++;
        if (moves == v.oor_k) begin
          oor    = 1'b1;
          oor_on = c;
        end
      end
      if (load) begin
        chk({v.name, " load_cycle"}, c, 1);
        loads++;
      end
      if (done) begin
        fin = 1'b1;
        e = sb.pop_front();
        chk({e.name, " done_lat"}, c, e.exp_lat);
        chk({e.name, " err"}, int'(err), e.exp_err);
        chk({e.name, " moves"}, moves, e.exp_moves);
        chk({e.name, " loads"}, loads, e.exp_loads);
        chk({e.name, " tap_pos"}, int'(tap_pos), e.exp_tap);
      end
    end
    oor = 1'b0;
    if (!fin) begin
      chk({v.name, " done_timeout"}, c, v.exp_lat);
      void'(sb.pop_front());
    end else begin
      @(negedge clk);
      chk({v.name, " ready_after"}, int'(req_ready), 1);
      chk({v.name, " done_one_cycle"}, int'(done), 0);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " ready"}, int'(req_ready), 0);
    chk({nm, " done"}, int'(done), 0);
    chk({nm, " err"}, int'(err), 0);
    chk({nm, " move"}, int'(move), 0);
    chk({nm, " load"}, int'(load), 0);
    chk({nm, " dir"}, int'(dir), 0);
    chk({nm, " tap"}, int'(tap_pos), 1);
  endtask

  initial begin
    //       name        op     taps  oor mv ld lat err tap
    vt[0]  = '{"inc3",    2'b00, 8'd3,   0, 3,   0, 14,  0, 4};
    vt[1]  = '{"dec6",    2'b01, 8'd6,   0, 4,   0, 18,  1, 0};
    vt[2]  = '{"dec1_at0",2'b01, 8'd1,   0, 0,   0, 2,   1, 0};
    vt[3]  = '{"load_a",  2'b10, 8'd9,   0, 0,   1, 6,   0, 1};
    vt[4]  = '{"inc10_oor",2'b00,8'd10,  2, 2,   0, 8,   1, 3};
    vt[5]  = '{"op11",    2'b11, 8'd5,   0, 0,   0, 1,   1, 3};
    vt[6]  = '{"inc0",    2'b00, 8'd0,   0, 0,   0, 1,   0, 3};
    vt[7]  = '{"dec0",    2'b01, 8'd0,   0, 0,   0, 1,   0, 3};
    vt[8]  = '{"dec2",    2'b01, 8'd2,   0, 2,   0, 10,  0, 1};
    vt[9]  = '{"inc255",  2'b00, 8'd255, 0, 126, 0, 506, 1, 127};
    vt[10] = '{"inc1_max",2'b00, 8'd1,   0, 0,   0, 2,   1, 127};
    vt[11] = '{"load_b",  2'b10, 8'd0,   0, 0,   1, 6,   0, 1};

    // Reset values while held, and READY rising only on the first edge after release.
    repeat (3) @(negedge clk);
    chk_reset_vals("rst_hold");
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", int'(req_ready), 0);
    @(negedge clk);
    chk("rst_first_edge_ready", int'(req_ready), 1);

    for (int i = 0; i < 12; i++) run(vt[i]);

    // Reset in the GAP of an increment: request abandoned, TAP_POS back to LOAD_TAP.
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_taps  = 8'd5;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_tap_before", int'(tap_pos), 2);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    repeat (2) @(negedge clk);
    chk("mid_rst_no_done", int'(done), 0);
    chk("mid_rst_no_move", int'(move), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", int'(req_ready), 1);
    chk("mid_rel_tap", int'(tap_pos), 1);
    repeat (20) begin
      @(negedge clk);
      if (done || move) chk("mid_rel_quiet", 1, 0);
    end
    chk("mid_rel_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
